// File: rtl/alu_exec_if.sv
// Bus between the operand/control side of the datapath and the ALU execution unit.
//   start_i     request strobe, sampled by the unit only while busy_o == 0
//   ALUCtrl_i   4-bit operation code from the ALU controller
//   src1_i      operand A (rs)
//   src2_i      operand B (rt or immediate)
//   busy_o      multiply in progress; new requests are dropped
//   done_o      one-cycle pulse when result_o/zero_o/overflow_o have been updated
//   result_o    registered result, held until the next done_o
//   zero_o      registered (result_o == 0)
//   overflow_o  registered signed overflow (ADD/SUB only)
interface alu_exec_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic [3:0]       ALUCtrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             overflow_o;

    modport master (
        output start_i, ALUCtrl_i, src1_i, src2_i,
        input  busy_o, done_o, result_o, zero_o, overflow_o
    );

    modport slave (
        input  start_i, ALUCtrl_i, src1_i, src2_i,
        output busy_o, done_o, result_o, zero_o, overflow_o
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle AND/OR/ADD/SUB/SLT, iterative shift-add MUL
// taking WIDTH cycles, with a start/busy/done handshake so the pipeline can stall.
//   clk_i  clock, rising edge
//   rst_i  synchronous reset, active low
//   bus    alu_exec_if slave: request, operands, result and status
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    alu_exec_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] sum, diff, alu_res, acc_next;
    logic             ovf_add, ovf_sub, alu_ovf, mul_last, start_mul;

    // Single-cycle operations; overflow from operand/result sign relationship
    always_comb begin
        sum     = bus.src1_i + bus.src2_i;
        diff    = bus.src1_i - bus.src2_i;
        ovf_add = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
                  (sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
        ovf_sub = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &&
                  (diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.ALUCtrl_i)
            OP_AND: alu_res = bus.src1_i & bus.src2_i;
            OP_OR:  alu_res = bus.src1_i | bus.src2_i;
            OP_ADD: begin alu_res = sum;  alu_ovf = ovf_add; end
            OP_SUB: begin alu_res = diff; alu_ovf = ovf_sub; end
            // Sign of the difference corrected by overflow gives the true signed compare
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
            default: begin alu_res = '0; alu_ovf = 1'b0; end
        endcase
    end

    assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last  = (cnt_q == CW'(WIDTH-1));
    assign start_mul = bus.start_i && (bus.ALUCtrl_i == OP_MUL);

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_mul) state_d = MUL;
            MUL:     if (mul_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the multiply datapath
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start_mul) begin
                    mcand_d  = bus.src1_i;
                    mplier_d = bus.src2_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end else if (bus.start_i) begin
                    done_d   = 1'b1;
                    result_d = alu_res;
                    zero_d   = (alu_res == '0);
                    ovf_d    = alu_ovf;
                end
            end
            MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (mul_last) begin
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = acc_next;
                    zero_d   = (acc_next == '0);
                    ovf_d    = 1'b0;
                end
            end
            default: busy_d = 1'b0;
        endcase
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.result_o   = result_q;
    assign bus.zero_o     = zero_q;
    assign bus.overflow_o = ovf_q;
endmodule
